// File: rtl/cfg_avmm_arb.sv
// Two-requester round-robin arbiter onto a single AVMM configuration port.
// One transaction in flight; each CMD/RDWAIT phase is bounded by a timeout abort.
module cfg_avmm_arb #(
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  i_cfg_avmm_clk,
    input  logic                  i_cfg_avmm_rst,
    input  logic [1:0]            i_req_read,
    input  logic [1:0]            i_req_write,
    input  logic [2*ADDR_W-1:0]   i_req_addr,
    input  logic [7:0]            i_req_byte_en,
    input  logic [2*DATA_W-1:0]   i_req_wdata,
    output logic [1:0]            o_req_waitreq,
    output logic [1:0]            o_req_rdatavld,
    output logic [1:0]            o_req_err,
    output logic [DATA_W-1:0]     o_req_rdata,
    output logic                  o_cfg_avmm_read,
    output logic                  o_cfg_avmm_write,
    output logic [ADDR_W-1:0]     o_cfg_avmm_addr,
    output logic [3:0]            o_cfg_avmm_byte_en,
    output logic [DATA_W-1:0]     o_cfg_avmm_wdata,
    input  logic                  i_cfg_avmm_waitreq,
    input  logic                  i_cfg_avmm_rdatavld,
    input  logic [DATA_W-1:0]     i_cfg_avmm_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [8:0] TMO_LIM = 9'(TIMEOUT);

    state_t              state_r;
    logic                last_gnt_r;
    logic                gnt_r;
    logic                wr_r;
    logic [7:0]          cnt_r;

    logic [1:0]          req_any_s;
    logic                gnt_s;
    logic                gnt_wr_s;
    logic [ADDR_W-1:0]   gnt_addr_s;
    logic [3:0]          gnt_be_s;
    logic [DATA_W-1:0]   gnt_wdata_s;
    logic [8:0]          cnt_inc_s;
    logic                tmo_s;
    logic [1:0]          gnt_oh_s;

    assign req_any_s = i_req_read | i_req_write;
    assign cnt_inc_s = {1'b0, cnt_r} + 9'd1;
    assign tmo_s     = (cnt_inc_s >= TMO_LIM);
    assign gnt_oh_s  = gnt_r ? 2'b10 : 2'b01;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        gnt_s = 1'b0;
        if (req_any_s == 2'b11) begin
            gnt_s = ~last_gnt_r;
        end else if (req_any_s[1]) begin
            gnt_s = 1'b1;
        end else begin
            gnt_s = 1'b0;
        end
        gnt_wr_s    = gnt_s ? i_req_write[1] : i_req_write[0];
        gnt_addr_s  = gnt_s ? i_req_addr[ADDR_W +: ADDR_W] : i_req_addr[0 +: ADDR_W];
        gnt_be_s    = gnt_s ? i_req_byte_en[7:4] : i_req_byte_en[3:0];
        gnt_wdata_s = gnt_s ? i_req_wdata[DATA_W +: DATA_W] : i_req_wdata[0 +: DATA_W];
    end

    // Transaction FSM with all requester and adapter outputs registered.
    always_ff @(posedge i_cfg_avmm_clk) begin
        if (i_cfg_avmm_rst) begin
            state_r            <= ST_IDLE;
            last_gnt_r         <= 1'b1;
            gnt_r              <= 1'b0;
            wr_r               <= 1'b0;
            cnt_r              <= 8'd0;
            o_req_waitreq      <= 2'b11;
            o_req_rdatavld     <= 2'b00;
            o_req_err          <= 2'b00;
            o_req_rdata        <= '0;
            o_cfg_avmm_read    <= 1'b0;
            o_cfg_avmm_write   <= 1'b0;
            o_cfg_avmm_addr    <= '0;
            o_cfg_avmm_byte_en <= 4'd0;
            o_cfg_avmm_wdata   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|req_any_s) begin
                        gnt_r              <= gnt_s;
                        last_gnt_r         <= gnt_s;
                        wr_r               <= gnt_wr_s;
                        cnt_r              <= 8'd0;
                        o_cfg_avmm_write   <= gnt_wr_s;
                        o_cfg_avmm_read    <= ~gnt_wr_s;
                        o_cfg_avmm_addr    <= gnt_addr_s;
                        o_cfg_avmm_byte_en <= gnt_be_s;
                        o_cfg_avmm_wdata   <= gnt_wdata_s;
                        state_r            <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (!i_cfg_avmm_waitreq) begin
                        o_cfg_avmm_read  <= 1'b0;
                        o_cfg_avmm_write <= 1'b0;
                        cnt_r            <= cnt_inc_s[7:0];
                        if (wr_r) begin
                            o_req_waitreq <= ~gnt_oh_s;
                            state_r       <= ST_DONE;
                        end else begin
                            state_r       <= ST_RDWAIT;
                        end
                    end else if (tmo_s) begin
                        o_cfg_avmm_read  <= 1'b0;
                        o_cfg_avmm_write <= 1'b0;
                        o_req_waitreq    <= ~gnt_oh_s;
                        o_req_err        <= gnt_oh_s;
                        o_req_rdatavld   <= wr_r ? 2'b00 : gnt_oh_s;
                        o_req_rdata      <= '0;
                        state_r          <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_inc_s[7:0];
                    end
                end
                ST_RDWAIT: begin
                    if (i_cfg_avmm_rdatavld) begin
                        o_req_rdata    <= i_cfg_avmm_rdata;
                        o_req_rdatavld <= gnt_oh_s;
                        o_req_waitreq  <= ~gnt_oh_s;
                        state_r        <= ST_DONE;
                    end else if (tmo_s) begin
                        o_req_waitreq  <= ~gnt_oh_s;
                        o_req_err      <= gnt_oh_s;
                        o_req_rdatavld <= gnt_oh_s;
                        o_req_rdata    <= '0;
                        state_r        <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_inc_s[7:0];
                    end
                end
                ST_DONE: begin
                    o_req_waitreq  <= 2'b11;
                    o_req_rdatavld <= 2'b00;
                    o_req_err      <= 2'b00;
                    state_r        <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_avmm_arb.sv
// Directed self-checking bench for cfg_avmm_arb (TIMEOUT=16 so abort paths are short).
module tb_cfg_avmm_arb;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;

    logic                  clk;
    logic                  rst;
    logic [1:0]            req_read;
    logic [1:0]            req_write;
    logic [2*ADDR_W-1:0]   req_addr;
    logic [7:0]            req_be;
    logic [2*DATA_W-1:0]   req_wdata;
    logic [1:0]            req_waitreq;
    logic [1:0]            req_rdatavld;
    logic [1:0]            req_err;
    logic [DATA_W-1:0]     req_rdata;
    logic                  av_read;
    logic                  av_write;
    logic [ADDR_W-1:0]     av_addr;
    logic [3:0]            av_be;
    logic [DATA_W-1:0]     av_wdata;
    logic                  av_waitreq;
    logic                  av_rdatavld;
    logic [DATA_W-1:0]     av_rdata;

    int errors = 0;
    int checks = 0;

    cfg_avmm_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
        .i_cfg_avmm_clk     (clk),
        .i_cfg_avmm_rst     (rst),
        .i_req_read         (req_read),
        .i_req_write        (req_write),
        .i_req_addr         (req_addr),
        .i_req_byte_en      (req_be),
        .i_req_wdata        (req_wdata),
        .o_req_waitreq      (req_waitreq),
        .o_req_rdatavld     (req_rdatavld),
        .o_req_err          (req_err),
        .o_req_rdata        (req_rdata),
        .o_cfg_avmm_read    (av_read),
        .o_cfg_avmm_write   (av_write),
        .o_cfg_avmm_addr    (av_addr),
        .o_cfg_avmm_byte_en (av_be),
        .o_cfg_avmm_wdata   (av_wdata),
        .i_cfg_avmm_waitreq (av_waitreq),
        .i_cfg_avmm_rdatavld(av_rdatavld),
        .i_cfg_avmm_rdata   (av_rdata)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; everything after returns 1 ns past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int n;

    initial begin
        rst         = 1'b1;
        req_read    = 2'b00;
        req_write   = 2'b00;
        req_addr    = '0;
        req_be      = 8'h00;
        req_wdata   = '0;
        av_waitreq  = 1'b0;
        av_rdatavld = 1'b0;
        av_rdata    = 32'h0;
        tick();
        tick();
        chk("rst_waitreq",  {62'd0, req_waitreq}, 64'd3);
        chk("rst_rdatavld", {62'd0, req_rdatavld}, 64'd0);
        chk("rst_err",      {62'd0, req_err}, 64'd0);
        chk("rst_rdata",    {32'd0, req_rdata}, 64'd0);
        chk("rst_strobes",  {62'd0, av_read, av_write}, 64'd0);
        chk("rst_addr",     {47'd0, av_addr}, 64'd0);
        rst = 1'b0;
        tick();

        // Zero-wait write from requester 0.
        req_write              = 2'b01;
        req_addr[0 +: ADDR_W]  = 17'h00208;
        req_be[3:0]            = 4'hF;
        req_wdata[0 +: DATA_W] = 32'hA5A5_0001;
        av_waitreq             = 1'b0;
        tick();
        chk("wr_strobe",  {62'd0, av_read, av_write}, 64'd1);
        chk("wr_addr",    {47'd0, av_addr}, 64'h208);
        chk("wr_data",    {32'd0, av_wdata}, 64'hA5A5_0001);
        chk("wr_be",      {60'd0, av_be}, 64'hF);
        chk("wr_wait_n1", {62'd0, req_waitreq}, 64'd3);
        tick();
        chk("wr_done_wait", {62'd0, req_waitreq}, 64'd2);
        chk("wr_done_strb", {62'd0, av_read, av_write}, 64'd0);
        chk("wr_done_vld",  {62'd0, req_rdatavld}, 64'd0);
        req_write = 2'b00;
        tick();
        chk("wr_idle_wait", {62'd0, req_waitreq}, 64'd3);
        tick();
        chk("wr_idle_strb", {62'd0, av_read, av_write}, 64'd0);

        // Simultaneous reads after reset: requester 0 first, then 1.
        do_reset();
        req_read                    = 2'b11;
        req_addr[0 +: ADDR_W]       = 17'h00010;
        req_addr[ADDR_W +: ADDR_W]  = 17'h00020;
        tick();
        chk("rr0_strobe", {62'd0, av_read, av_write}, 64'd2);
        chk("rr0_addr",   {47'd0, av_addr}, 64'h10);
        tick();
        chk("rr0_rdwait", {62'd0, av_read, av_write}, 64'd0);
        av_rdatavld = 1'b1;
        av_rdata    = 32'hAAAA_0000;
        tick();
        av_rdatavld = 1'b0;
        chk("rr0_vld",   {62'd0, req_rdatavld}, 64'd1);
        chk("rr0_rdata", {32'd0, req_rdata}, 64'hAAAA_0000);
        chk("rr0_wait",  {62'd0, req_waitreq}, 64'd2);
        req_read = 2'b10;
        tick();
        chk("rr_hold_rdata", {32'd0, req_rdata}, 64'hAAAA_0000);
        tick();
        chk("rr1_strobe", {62'd0, av_read, av_write}, 64'd2);
        chk("rr1_addr",   {47'd0, av_addr}, 64'h20);
        tick();
        av_rdatavld = 1'b1;
        av_rdata    = 32'hBBBB_1111;
        tick();
        av_rdatavld = 1'b0;
        chk("rr1_vld",   {62'd0, req_rdatavld}, 64'd2);
        chk("rr1_rdata", {32'd0, req_rdata}, 64'hBBBB_1111);
        chk("rr1_wait",  {62'd0, req_waitreq}, 64'd1);
        req_read = 2'b00;
        tick();
        tick();

        // Read+write together is a write.
        req_read              = 2'b01;
        req_write             = 2'b01;
        req_addr[0 +: ADDR_W] = 17'h00044;
        tick();
        chk("rw_strobe", {62'd0, av_read, av_write}, 64'd1);
        tick();
        chk("rw_vld",  {62'd0, req_rdatavld}, 64'd0);
        chk("rw_wait", {62'd0, req_waitreq}, 64'd2);
        req_read  = 2'b00;
        req_write = 2'b00;
        tick();
        tick();

        // Requester 1 read: 3 stalled cycles, late data; request dropped early.
        req_read                   = 2'b10;
        req_addr[ADDR_W +: ADDR_W] = 17'h1ABCD;
        av_waitreq                 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) begin
                req_read    = 2'b00;
                av_rdatavld = 1'b1;
                av_rdata    = 32'hDEAD_BEEF;
            end else begin
                av_rdatavld = 1'b0;
            end
            chk("st_strobe", {62'd0, av_read, av_write}, 64'd2);
            chk("st_addr",   {47'd0, av_addr}, 64'h1ABCD);
            chk("st_vld",    {62'd0, req_rdatavld}, 64'd0);
            if (i == 3) av_waitreq = 1'b0;
        end
        tick();
        chk("st_strobe_off", {62'd0, av_read, av_write}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("st_rdwait", {62'd0, req_waitreq}, 64'd3);
        end
        av_rdatavld = 1'b1;
        av_rdata    = 32'h1234_5678;
        tick();
        av_rdatavld = 1'b0;
        chk("st_vld_done", {62'd0, req_rdatavld}, 64'd2);
        chk("st_rdata",    {32'd0, req_rdata}, 64'h1234_5678);
        chk("st_err",      {62'd0, req_err}, 64'd0);
        tick();
        tick();

        // Write timeout with the adapter stuck in waitrequest.
        req_write  = 2'b01;
        av_waitreq = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("to_strobe", {62'd0, av_read, av_write}, 64'd1);
        end
        tick();
        chk("to_err",    {62'd0, req_err}, 64'd1);
        chk("to_wait",   {62'd0, req_waitreq}, 64'd2);
        chk("to_strobe_off", {62'd0, av_read, av_write}, 64'd0);
        chk("to_vld",    {62'd0, req_rdatavld}, 64'd0);
        req_write = 2'b00;
        tick();
        chk("to_err_off", {62'd0, req_err}, 64'd0);
        chk("to_idle_wait", {62'd0, req_waitreq}, 64'd3);
        tick();
        chk("to_idle_strb", {62'd0, av_read, av_write}, 64'd0);

        // Read timeout in RDWAIT: zero data with a valid pulse.
        req_read   = 2'b10;
        av_waitreq = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) req_read = 2'b00;
        end while (req_err == 2'b00 && n < 40);
        chk("tor_cycles", 64'(n), 64'd17);
        chk("tor_err",    {62'd0, req_err}, 64'd2);
        chk("tor_vld",    {62'd0, req_rdatavld}, 64'd2);
        chk("tor_rdata",  {32'd0, req_rdata}, 64'd0);
        tick();
        tick();

        // Reset while waiting for read data; late data must be ignored.
        req_read              = 2'b01;
        req_addr[0 +: ADDR_W] = 17'h00777;
        tick();
        tick();
        req_read = 2'b00;
        rst      = 1'b1;
        tick();
        rst         = 1'b0;
        av_rdatavld = 1'b1;
        av_rdata    = 32'hCAFE_F00D;
        tick();
        av_rdatavld = 1'b0;
        chk("rrst_vld",   {62'd0, req_rdatavld}, 64'd0);
        chk("rrst_wait",  {62'd0, req_waitreq}, 64'd3);
        chk("rrst_rdata", {32'd0, req_rdata}, 64'd0);
        chk("rrst_strb",  {62'd0, av_read, av_write}, 64'd0);
        chk("rrst_addr",  {47'd0, av_addr}, 64'd0);
        tick();
        chk("rrst_vld2",  {62'd0, req_rdatavld}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
